// File: rtl/ltc2308_responder.sv
// Behavioural stand-in for an LTC2308 ADC on the serial side: answers driver frames with
// 12-bit codes taken from a parallel sample bus, using the pipelined config of the real part.
module ltc2308_responder #(
  parameter int unsigned CONV_CYCLES = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        adc_cs_n,
  input  logic        adc_sclk,
  input  logic        adc_din,
  output logic        adc_dout,
  input  logic [95:0] sample_in,
  output logic [5:0]  config_out,
  output logic        conv_busy,
  output logic        frame_done,
  output logic        protocol_error
);

  localparam int unsigned CntW     = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [5:0]  CfgReset = 6'b100010;

  typedef enum logic [1:0] {StIdle, StShift, StConv} state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, din_sync_q;
  logic                   cs_prev_q, sclk_prev_q;
  logic                   cs_s, sclk_s, din_s;
  logic                   cs_fall, cs_rise, sclk_rise, sclk_fall;

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign din_s     = din_sync_q[SYNC_STAGES-1];
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      din_sync_q  <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], adc_cs_n};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], adc_sclk};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], adc_din};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
    end
  end

  state_e            state_q, state_d;
  logic [11:0]       tx_q, tx_d;
  logic [5:0]        cfg_sh_q, cfg_sh_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [11:0]       conv_sample_q, conv_sample_d;
  logic [11:0]       result_q, result_d;
  logic [5:0]        config_q, config_d;
  logic              dout_q, dout_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [5:0]        new_cfg;
  logic [2:0]        ch_idx;
  logic [11:0]       ch_val;

  // Short frames (<6 config bits) keep the previous config; channel = {S1,S0,O/S}.
  assign new_cfg = (bit_cnt_q >= 4'd6) ? cfg_sh_q : config_q;
  assign ch_idx  = {new_cfg[3], new_cfg[2], new_cfg[4]};
  assign ch_val  = sample_in[32'(ch_idx) * 12 +: 12];

  always_comb begin
    state_d       = state_q;
    tx_d          = tx_q;
    cfg_sh_d      = cfg_sh_q;
    bit_cnt_d     = bit_cnt_q;
    cnt_d         = cnt_q;
    conv_sample_d = conv_sample_q;
    result_d      = result_q;
    config_d      = config_q;
    dout_d        = dout_q;
    done_d        = 1'b0;
    err_d         = err_q;
    if (!enable) begin
      state_d = StIdle;
      dout_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            tx_d      = result_q;
            dout_d    = result_q[11];
            bit_cnt_d = 4'd0;
            state_d   = StShift;
          end
        end
        StShift: begin
          // cs_n rise wins over a coincident sclk edge, which is dropped.
          if (cs_rise) begin
            config_d      = new_cfg;
            err_d         = err_q | (bit_cnt_q != 4'd12);
            conv_sample_d = ch_val;
            done_d        = 1'b1;
            cnt_d         = CntW'(CONV_CYCLES - 1);
            dout_d        = 1'b0;
            state_d       = StConv;
          end else if (sclk_rise) begin
            if (bit_cnt_q < 4'd6) cfg_sh_d = {cfg_sh_q[4:0], din_s};
            if (bit_cnt_q != 4'd15) bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (sclk_fall) begin
            // Zeros shift in, so dout falls to 0 once all 12 bits are out.
            tx_d   = {tx_q[10:0], 1'b0};
            dout_d = tx_q[10];
          end
        end
        StConv: begin
          if (cs_fall) err_d = 1'b1;
          if (cnt_q == '0) begin
            result_d = config_q[1] ? conv_sample_q : (conv_sample_q ^ 12'h800);
            state_d  = StIdle;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      tx_q          <= '0;
      cfg_sh_q      <= '0;
      bit_cnt_q     <= '0;
      cnt_q         <= '0;
      conv_sample_q <= '0;
      result_q      <= '0;
      config_q      <= CfgReset;
      dout_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_q          <= tx_d;
      cfg_sh_q      <= cfg_sh_d;
      bit_cnt_q     <= bit_cnt_d;
      cnt_q         <= cnt_d;
      conv_sample_q <= conv_sample_d;
      result_q      <= result_d;
      config_q      <= config_d;
      dout_q        <= dout_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign adc_dout       = dout_q;
  assign config_out     = config_q;
  assign conv_busy      = (state_q == StConv);
  assign frame_done     = done_q;
  assign protocol_error = err_q;

endmodule

// File: tb/tb_ltc2308_responder.sv
// Self-checking bench: drives driver-style serial frames and compares read-back codes, config
// and flags against a frame-level model of the converter.
module tb_ltc2308_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        adc_cs_n = 1'b1;
  logic        adc_sclk = 1'b0;
  logic        adc_din = 1'b0;
  logic        adc_dout;
  logic [95:0] sample_in = '0;
  logic [5:0]  config_out;
  logic        conv_busy, frame_done, protocol_error;

  int checks = 0;
  int passes = 0;

  logic [11:0] m_result;
  logic [5:0]  m_cfg;
  logic        m_err;

  always #5 clk = ~clk;

  ltc2308_responder #(.CONV_CYCLES(64), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .adc_cs_n(adc_cs_n),
    .adc_sclk(adc_sclk), .adc_din(adc_din), .adc_dout(adc_dout), .sample_in(sample_in),
    .config_out(config_out), .conv_busy(conv_busy), .frame_done(frame_done),
    .protocol_error(protocol_error)
  );

  function automatic logic [11:0] chan(input logic [95:0] s, input int k);
    return s[k*12 +: 12];
  endfunction

  task automatic set_chan(input int k, input logic [11:0] v);
    sample_in[k*12 +: 12] = v;
  endtask

  task automatic model_reset();
    m_result = 12'h000;
    m_cfg    = 6'b100010;
    m_err    = 1'b0;
  endtask

  // Converter behaviour for one completed frame with nbits sclk pulses.
  task automatic model_frame(input logic [5:0] cfg, input int nbits);
    int idx;
    logic [11:0] s;
    if (nbits >= 6) m_cfg = cfg;
    if (nbits != 12) m_err = 1'b1;
    idx = (m_cfg[3] ? 4 : 0) + (m_cfg[2] ? 2 : 0) + (m_cfg[4] ? 1 : 0);
    s = chan(sample_in, idx);
    m_result = m_cfg[1] ? s : 12'((int'(s) + 2048) % 4096);
  endtask

  task automatic apply_reset();
    reset_n  = 1'b0;
    enable   = 1'b1;
    adc_cs_n = 1'b1;
    adc_sclk = 1'b0;
    adc_din  = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    model_reset();
  endtask

  // sclk half period is 4 clks; dout is read just before each sclk rise.
  task automatic run_frame(input logic [5:0] cfg, input int nbits, output logic [11:0] rd);
    rd = '0;
    @(negedge clk);
    adc_cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      adc_din = (i < 6) ? cfg[5-i] : 1'($urandom);
      repeat (4) @(negedge clk);
      if (i < 12) rd[11-i] = adc_dout;
      adc_sclk = 1'b1;
      repeat (4) @(negedge clk);
      adc_sclk = 1'b0;
    end
    repeat (6) @(negedge clk);
    adc_cs_n = 1'b1;
    adc_din  = 1'b0;
  endtask

  task automatic wait_conv(output int busy_cnt, output logic done_ok, output logic pulse_ok);
    int n;
    n = 0;
    busy_cnt = 0;
    done_ok = 1'b0;
    pulse_ok = 1'b0;
    while (!frame_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (frame_done) begin
      done_ok = 1'b1;
      busy_cnt = conv_busy ? 1 : 0;
      @(negedge clk);
      pulse_ok = !frame_done;
      while (conv_busy && busy_cnt < 300) begin
        busy_cnt++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (adc_dout !== 1'b0) $display("FAIL reset_dout: got %b want 0", adc_dout);
    else passes++;
    checks++; if (config_out !== 6'b100010)
      $display("FAIL reset_config: got %b want 100010", config_out);
    else passes++;
    checks++; if (conv_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", conv_busy);
    else passes++;
    checks++; if (frame_done !== 1'b0) $display("FAIL reset_done: got %b want 0", frame_done);
    else passes++;
    checks++; if (protocol_error !== 1'b0)
      $display("FAIL reset_err: got %b want 0", protocol_error);
    else passes++;
  endtask

  task automatic test_basic();
    logic [11:0] rd;
    int bc;
    logic dok, pok;
    sample_in = {$urandom, $urandom, $urandom};
    set_chan(0, 12'hABC);
    run_frame(6'b100010, 12, rd);
    model_frame(6'b100010, 12);
    checks++; if (rd !== 12'h000) $display("FAIL basic_first_read: got %h want 000", rd);
    else passes++;
    wait_conv(bc, dok, pok);
    checks++; if (dok !== 1'b1) $display("FAIL basic_done: got %b want 1", dok);
    else passes++;
    checks++; if (pok !== 1'b1) $display("FAIL basic_done_width: got %b want 1", pok);
    else passes++;
    checks++; if (bc != 64) $display("FAIL basic_busy_len: got %0d want 64", bc);
    else passes++;
    sample_in = {$urandom, $urandom, $urandom};
    set_chan(1, 12'h123);
    run_frame(6'b110010, 12, rd);
    checks++; if (rd !== 12'hABC) $display("FAIL basic_second_read: got %h want abc", rd);
    else passes++;
    model_frame(6'b110010, 12);
    wait_conv(bc, dok, pok);
    checks++; if (config_out !== 6'b110010)
      $display("FAIL basic_config: got %b want 110010", config_out);
    else passes++;
    sample_in = {$urandom, $urandom, $urandom};
    run_frame(6'b100010, 12, rd);
    checks++; if (rd !== 12'h123) $display("FAIL basic_ch1_read: got %h want 123", rd);
    else passes++;
    model_frame(6'b100010, 12);
    wait_conv(bc, dok, pok);
    checks++; if (protocol_error !== 1'b0)
      $display("FAIL basic_err: got %b want 0", protocol_error);
    else passes++;
  endtask

  task automatic test_bipolar();
    logic [11:0] rd;
    int bc;
    logic dok, pok;
    set_chan(0, 12'h000);
    run_frame(6'b100000, 12, rd);
    model_frame(6'b100000, 12);
    wait_conv(bc, dok, pok);
    set_chan(0, 12'hFFF);
    run_frame(6'b100000, 12, rd);
    checks++; if (rd !== 12'h800) $display("FAIL bipolar_zero: got %h want 800", rd);
    else passes++;
    model_frame(6'b100000, 12);
    wait_conv(bc, dok, pok);
    run_frame(6'b100010, 12, rd);
    checks++; if (rd !== 12'h7FF) $display("FAIL bipolar_full: got %h want 7ff", rd);
    else passes++;
    model_frame(6'b100010, 12);
    wait_conv(bc, dok, pok);
  endtask

  task automatic test_random_channels();
    logic [11:0] rd, exp;
    logic [5:0] cfg;
    int bc;
    logic dok, pok;
    for (int it = 0; it < 8; it++) begin
      sample_in = {$urandom, $urandom, $urandom};
      cfg = 6'($urandom);
      exp = m_result;
      run_frame(cfg, 12, rd);
      checks++; if (rd !== exp) $display("FAIL rand_read[%0d]: got %h want %h", it, rd, exp);
      else passes++;
      model_frame(cfg, 12);
      wait_conv(bc, dok, pok);
      // Post-capture changes must not reach the result.
      sample_in = {$urandom, $urandom, $urandom};
      checks++; if (dok !== 1'b1) $display("FAIL rand_done[%0d]: got %b want 1", it, dok);
      else passes++;
      checks++; if (config_out !== m_cfg)
        $display("FAIL rand_config[%0d]: got %b want %b", it, config_out, m_cfg);
      else passes++;
    end
  endtask

  task automatic test_short_frame();
    logic [11:0] rd, exp;
    logic [5:0] cfg;
    int bc;
    logic dok, pok;
    sample_in = {$urandom, $urandom, $urandom};
    cfg = ~m_cfg;
    run_frame(cfg, 4, rd);
    model_frame(cfg, 4);
    wait_conv(bc, dok, pok);
    checks++; if (dok !== 1'b1) $display("FAIL short_done: got %b want 1", dok);
    else passes++;
    checks++; if (config_out !== m_cfg)
      $display("FAIL short_config: got %b want %b", config_out, m_cfg);
    else passes++;
    checks++; if (protocol_error !== 1'b1)
      $display("FAIL short_err: got %b want 1", protocol_error);
    else passes++;
    exp = m_result;
    sample_in = {$urandom, $urandom, $urandom};
    run_frame(m_cfg, 12, rd);
    checks++; if (rd !== exp) $display("FAIL short_next_read: got %h want %h", rd, exp);
    else passes++;
    model_frame(m_cfg, 12);
    wait_conv(bc, dok, pok);
  endtask

  task automatic test_async_reset();
    logic [11:0] rd;
    int bc;
    logic dok, pok;
    @(negedge clk);
    adc_cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      adc_sclk = 1'b1;
      repeat (4) @(negedge clk);
      adc_sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({adc_dout, conv_busy, frame_done, protocol_error} !== 4'b0000)
      $display("FAIL arst_flags: got %b want 0000",
               {adc_dout, conv_busy, frame_done, protocol_error});
    else passes++;
    checks++; if (config_out !== 6'b100010)
      $display("FAIL arst_config: got %b want 100010", config_out);
    else passes++;
    adc_cs_n = 1'b1;
    apply_reset();
    run_frame(6'b100010, 12, rd);
    checks++; if (rd !== 12'h000) $display("FAIL arst_result: got %h want 000", rd);
    else passes++;
    model_frame(6'b100010, 12);
    wait_conv(bc, dok, pok);
  endtask

  task automatic test_conv_overlap();
    logic [11:0] rd, a;
    int n, dout_hi, busy_hi;
    logic dok, pok;
    apply_reset();
    sample_in = {$urandom, $urandom, $urandom};
    a = chan(sample_in, 0);
    run_frame(6'b100010, 12, rd);
    model_frame(6'b100010, 12);
    repeat (10) @(negedge clk);
    adc_cs_n = 1'b0;
    set_chan(0, ~a);
    dout_hi = 0;
    for (int i = 0; i < 3; i++) begin
      adc_din = 1'b1;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (adc_dout !== 1'b0) dout_hi++;
        adc_sclk = (k < 3) ? 1'b0 : 1'b1;
      end
      adc_sclk = 1'b0;
    end
    adc_cs_n = 1'b1;
    adc_din  = 1'b0;
    m_err = 1'b1;
    checks++; if (dout_hi != 0) $display("FAIL overlap_dout: got %0d high samples want 0", dout_hi);
    else passes++;
    n = 0;
    while (conv_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (conv_busy !== 1'b0) $display("FAIL overlap_conv_end: got busy %b want 0", conv_busy);
    else passes++;
    checks++; if (protocol_error !== 1'b1)
      $display("FAIL overlap_err: got %b want 1", protocol_error);
    else passes++;
    busy_hi = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (conv_busy !== 1'b0) busy_hi++;
    end
    checks++; if (busy_hi != 0) $display("FAIL overlap_second_conv: got %0d busy want 0", busy_hi);
    else passes++;
    run_frame(6'b100010, 12, rd);
    checks++; if (rd !== a) $display("FAIL overlap_result: got %h want %h", rd, a);
    else passes++;
    model_frame(6'b100010, 12);
    wait_conv(n, dok, pok);
  endtask

  task automatic test_enable_abort();
    logic [11:0] rd, x;
    int bc, done_cnt;
    logic dok, pok;
    apply_reset();
    x = 12'($urandom) | 12'h040;
    set_chan(0, x);
    run_frame(6'b100010, 12, rd);
    model_frame(6'b100010, 12);
    wait_conv(bc, dok, pok);
    set_chan(0, ~x);
    @(negedge clk);
    adc_cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      adc_sclk = 1'b1;
      repeat (4) @(negedge clk);
      adc_sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    checks++; if (adc_dout !== x[6]) $display("FAIL abort_pre_dout: got %b want %b", adc_dout, x[6]);
    else passes++;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (adc_dout !== 1'b0) $display("FAIL abort_dout: got %b want 0", adc_dout);
    else passes++;
    adc_cs_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (frame_done || conv_busy) done_cnt++;
    end
    checks++; if (done_cnt != 0) $display("FAIL abort_activity: got %0d want 0", done_cnt);
    else passes++;
    checks++; if (protocol_error !== 1'b0)
      $display("FAIL abort_err: got %b want 0", protocol_error);
    else passes++;
    checks++; if (config_out !== m_cfg)
      $display("FAIL abort_config: got %b want %b", config_out, m_cfg);
    else passes++;
    enable = 1'b1;
    repeat (4) @(negedge clk);
    run_frame(6'b100010, 12, rd);
    checks++; if (rd !== x) $display("FAIL abort_result: got %h want %h", rd, x);
    else passes++;
    model_frame(6'b100010, 12);
    wait_conv(bc, dok, pok);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bipolar();
    test_random_channels();
    test_short_frame();
    test_async_reset();
    test_conv_overlap();
    test_enable_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
